idli_sqi_resp_m: RTL and testbench
==================================

# idli_sqi_resp_m

Synthesizable SQI (quad-SPI) memory responder: the target end of the SQI bus that the core drives as initiator. It decodes the read/write command, address and data nibbles clocked in on SCK, and serves or stores bytes in an internal byte array. It lets the core run against on-die or FPGA-emulated memory in place of an external SQI SRAM, and serves as the bus model in core-level benches.

## Interface
Parameters:
- ADDR_W, 8, byte address width of internal storage (2^ADDR_W bytes); upper address bits are ignored.

Ports:
- i_sqi_gck  in  1  clock, shared with the initiator; SCK is a signal sampled by this clock.
- i_sqi_rst  in  1  reset, asynchronous, active-high.
- i_sqi_sck  in  1  SQI serial clock from the initiator.
- i_sqi_cs  in  1  chip select, active-low (0 = selected).
- i_sqi_data  in  4  nibble from the initiator.
- o_sqi_data  out  4  nibble to the initiator; reset 4'h0.
- o_sqi_oe  out  1  1 = responder drives the data lines; reset 0.
- o_sqi_busy  out  1  1 = not in IDLE; reset 0.

## Operation
- Edge detect: sck_q is SCK registered on gck. rise = sck & ~sck_q; fall = ~sck & sck_q. Edges are ignored while cs = 1.
- Transaction layout, most-significant nibble first: command 2 nibbles, address 6 nibbles (24 bits, low ADDR_W used). Reads add 2 dummy nibbles, then data; writes follow directly with data.
- Commands: 8'h03 READ, 8'h02 WRITE. Any other value goes to IGNORE and stays there until cs rises; no output is driven and nothing is written.
- States and transitions:
  - IDLE -> CMD on the first rise with cs = 0.
  - CMD -> ADDR after 2 nibbles.
  - ADDR -> DUMMY (READ) or WDATA (WRITE) after 6 nibbles.
  - DUMMY -> RDATA after 2 nibbles.
  - RDATA and WDATA stay until cs = 1.
- Nibble counter: 3 bits, cleared on each state change.
- WDATA: the first rise latches the high nibble, the second rise writes the byte to mem[addr]. addr then increments modulo 2^ADDR_W.
- RDATA: on each fall, o_sqi_data takes the next nibble of mem[addr], high nibble first. After the low nibble is driven, addr increments modulo 2^ADDR_W.
- o_sqi_oe is set on the first fall after the final dummy rise, and cleared when cs = 1 or in any non-RDATA state.
- cs = 1 at any time forces IDLE, oe = 0, and busy = 0 on the next gck. A half-received write byte is discarded; bytes already written remain.
- Reset clears state, counters, addr, outputs and sck_q. Storage contents are not reset (X until written).

## Timing
- Edge seen on the gck edge where SCK first reads its new value. State and storage update on that same gck edge, so state is visible one cycle after the SCK transition.
- The READ first nibble appears on o_sqi_data one gck after the SCK fall following the last dummy rise. The initiator samples it on the next SCK rise.
- Minimum SCK phase: 1 gck high and 1 gck low; all counters must tolerate sck toggling every gck.
- A storage write occurs on the same gck as the second data-nibble rise. A read of that byte in a later transaction returns the new value.
- Simultaneous cs rise and SCK edge: the cs rise wins and the edge is discarded.

## Structure
- idli_pkg: constants SQI_CMD_READ = 8'h03 and SQI_CMD_WRITE = 8'h02; enum sqi_resp_state_t {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE}; SQI_ADDR_NIBBLES = 6; SQI_DUMMY_NIBBLES = 2.
- Sub-module idli_sqi_resp_mem_m holds the 2^ADDR_W x 8 storage, with one synchronous write port and one asynchronous read port.
- The top level holds the edge detect, FSM, nibble counter, address register and output regs.

## Test plan
- Reset: assert i_sqi_rst mid-stream -> o_sqi_oe = 0, o_sqi_data = 0, o_sqi_busy = 0 immediately; the next cs-low transaction decodes normally.
- Write/read: WRITE 0x000010 with bytes A5, 3C; then READ 0x000010 for 2 bytes -> nibbles A,5,3,C; oe rises only after the 2 dummy nibbles.
- Wrap/alias: WRITE 0x1234FF with 11, 22 -> mem[FF] = 11, mem[00] = 22. READ 0x0000FF for 2 bytes -> 1,1,2,2.
- Unknown command 0x05 followed by 16 nibbles -> oe stays 0, storage is unchanged, busy stays 1 until cs = 1.
- Abort: WRITE 0x20 with byte 77, then 1 nibble of 9, then cs = 1 -> mem[20] = 77, mem[21] is unchanged, FSM is IDLE one gck later.
- Fast SCK: SCK toggles every gck through a full READ of 4 bytes -> data matches with no dropped or duplicated nibble.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared SQI responder constants and state type.
// Command codes, transaction phase lengths, FSM encoding.
package idli_pkg;

    localparam logic [7:0] SQI_CMD_READ  = 8'h03;
    localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

    localparam int SQI_ADDR_NIBBLES  = 6;
    localparam int SQI_DUMMY_NIBBLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } sqi_resp_state_t;

endpackage

// File: rtl/idli_sqi_resp_m_if.sv
// SQI bus bundle between initiator (master) and responder (slave).
// Clock and reset stay outside as plain ports.
interface idli_sqi_resp_m_if;

    logic       i_sqi_sck;
    logic       i_sqi_cs;
    logic [3:0] i_sqi_data;
    logic [3:0] o_sqi_data;
    logic       o_sqi_oe;
    logic       o_sqi_busy;

    modport master (
        output i_sqi_sck,
        output i_sqi_cs,
        output i_sqi_data,
        input  o_sqi_data,
        input  o_sqi_oe,
        input  o_sqi_busy
    );

    modport slave (
        input  i_sqi_sck,
        input  i_sqi_cs,
        input  i_sqi_data,
        output o_sqi_data,
        output o_sqi_oe,
        output o_sqi_busy
    );

endinterface

// File: rtl/idli_sqi_resp_mem_m.sv
// Byte storage for the SQI responder.
// One synchronous write port, one asynchronous read port, no reset.
module idli_sqi_resp_mem_m #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [2**ADDR_W];

    // Store a byte when the write strobe is up.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/idli_sqi_resp_m.sv
// SQI memory responder: decodes READ/WRITE transactions clocked on SCK
// and serves or stores bytes in internal storage.
module idli_sqi_resp_m
    import idli_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              i_sqi_gck,
    input  logic              i_sqi_rst,
    idli_sqi_resp_m_if.slave  sqi
);

    sqi_resp_state_t   state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        cmd_hi_q, cmd_hi_d;
    logic [3:0]        wr_hi_q, wr_hi_d;
    logic              rd_q, rd_d;
    logic [3:0]        data_q, data_d;
    logic              oe_q, oe_d;
    logic              sck_q;
    logic              rise, fall;
    logic              we;
    logic [7:0]        rdata;
    logic [7:0]        cmd;
    logic [ADDR_W+3:0] addr_sh;

    assign rise = sqi.i_sqi_sck & ~sck_q;
    assign fall = ~sqi.i_sqi_sck & sck_q;
    assign cmd  = {cmd_hi_q, sqi.i_sqi_data};
    assign addr_sh = {addr_q, sqi.i_sqi_data};

    idli_sqi_resp_mem_m #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (i_sqi_gck),
        .we_i    (we),
        .waddr_i (addr_q),
        .wdata_i ({wr_hi_q, sqi.i_sqi_data}),
        .raddr_i (addr_q),
        .rdata_o (rdata)
    );

    // State, counters, address and output registers.
    always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
        if (i_sqi_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            cmd_hi_q <= '0;
            wr_hi_q  <= '0;
            rd_q     <= 1'b0;
            data_q   <= '0;
            oe_q     <= 1'b0;
            sck_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            cmd_hi_q <= cmd_hi_d;
            wr_hi_q  <= wr_hi_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            oe_q     <= oe_d;
            sck_q    <= sqi.i_sqi_sck;
        end
    end

    // Transaction decode; a deselect overrides any coincident SCK edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        cmd_hi_d = cmd_hi_q;
        wr_hi_d  = wr_hi_q;
        rd_d     = rd_q;
        data_d   = data_q;
        oe_d     = oe_q;
        we       = 1'b0;
        if (sqi.i_sqi_cs) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (rise) begin
                    cmd_hi_d = sqi.i_sqi_data;
                    cnt_d    = '0;
                    state_d  = CMD;
                end
                CMD: if (rise) begin
                    cnt_d = '0;
                    if (cmd == SQI_CMD_READ) begin
                        rd_d    = 1'b1;
                        state_d = ADDR;
                    end else if (cmd == SQI_CMD_WRITE) begin
                        rd_d    = 1'b0;
                        state_d = ADDR;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                ADDR: if (rise) begin
                    addr_d = addr_sh[ADDR_W-1:0];
                    if (cnt_q == 3'(SQI_ADDR_NIBBLES - 1)) begin
                        cnt_d   = '0;
                        state_d = rd_q ? DUMMY : WDATA;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                DUMMY: if (rise) begin
                    if (cnt_q == 3'(SQI_DUMMY_NIBBLES - 1)) begin
                        cnt_d   = '0;
                        state_d = RDATA;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                RDATA: if (fall) begin
                    oe_d = 1'b1;
                    if (!cnt_q[0]) begin
                        data_d = rdata[7:4];
                        cnt_d  = 3'd1;
                    end else begin
                        data_d = rdata[3:0];
                        cnt_d  = '0;
                        addr_d = addr_q + 1'b1;
                    end
                end
                WDATA: if (rise) begin
                    if (!cnt_q[0]) begin
                        wr_hi_d = sqi.i_sqi_data;
                        cnt_d   = 3'd1;
                    end else begin
                        we     = 1'b1;
                        cnt_d  = '0;
                        addr_d = addr_q + 1'b1;
                    end
                end
                IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
        if (state_d != RDATA) begin
            oe_d = 1'b0;
        end
    end

    assign sqi.o_sqi_data = data_q;
    assign sqi.o_sqi_oe   = oe_q;
    assign sqi.o_sqi_busy = (state_q != IDLE);

endmodule

// File: tb/tb_idli_sqi_resp_m.sv
// Bench for idli_sqi_resp_m: acts as SQI initiator and checks reads
// against a byte-array model of the responder's storage.
module tb_idli_sqi_resp_m;

    logic gck = 1'b0;
    logic rst = 1'b1;
    always #5 gck = ~gck;

    idli_sqi_resp_m_if bus ();

    idli_sqi_resp_m #(
        .ADDR_W (8)
    ) dut (
        .i_sqi_gck (gck),
        .i_sqi_rst (rst),
        .sqi       (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    int ph = 2;
    logic [7:0] mdl [256];
    bit vld [256];
    bit rd_win = 1'b0;
    logic [3:0] rx [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One SCK phase: sample DUT outputs, then move SCK.
    task automatic half(input logic v, output logic [3:0] d,
                        output logic oe);
        @(negedge gck);
        d = bus.o_sqi_data;
        oe = bus.o_sqi_oe;
        bus.i_sqi_sck = v;
        repeat (ph - 1) @(negedge gck);
    endtask

    task automatic send(input logic [3:0] n);
        logic [3:0] d;
        logic oe;
        half(1'b0, d, oe);
        bus.i_sqi_data = n;
        half(1'b1, d, oe);
    endtask

    task automatic begin_tx(input logic [7:0] c, input logic [23:0] a);
        @(negedge gck);
        bus.i_sqi_cs = 1'b0;
        send(c[7:4]);
        send(c[3:0]);
        for (int i = 5; i >= 0; i--) send(a[i*4 +: 4]);
    endtask

    task automatic end_tx();
        @(negedge gck);
        bus.i_sqi_cs = 1'b1;
        rd_win = 1'b0;
        @(negedge gck);
        bus.i_sqi_sck = 1'b0;
        repeat (2) @(negedge gck);
    endtask

    task automatic write_tx(input logic [23:0] a, input logic [7:0] b [$]);
        int p;
        p = int'(a[7:0]);
        begin_tx(8'h02, a);
        foreach (b[i]) begin
            send(b[i][7:4]);
            send(b[i][3:0]);
            mdl[p] = b[i];
            vld[p] = 1'b1;
            p = (p + 1) % 256;
        end
        end_tx();
    endtask

    task automatic read_tx(input logic [23:0] a, input int n);
        logic [3:0] d;
        logic oe;
        logic [7:0] eb;
        int p;
        rx.delete();
        begin_tx(8'h03, a);
        send(4'h0);
        send(4'h0);
        chk("oe_after_dummy", 32'(bus.o_sqi_oe), 0);
        rd_win = 1'b1;
        for (int i = 0; i < 2 * n; i++) begin
            half(1'b0, d, oe);
            half(1'b1, d, oe);
            rx.push_back(d);
            chk("rd_oe", 32'(oe), 1);
            p = (int'(a[7:0]) + i / 2) % 256;
            if (vld[p]) begin
                eb = mdl[p];
                chk("rd_nibble", 32'(d), 32'((i % 2 == 0) ? eb[7:4] : eb[3:0]));
            end
        end
        end_tx();
    endtask

    // Per-cycle monitor: deselected means idle, oe only in read data.
    always @(posedge gck) begin
        #1;
        if (!rst) begin
            if (bus.i_sqi_cs) begin
                chk("idle_busy", 32'(bus.o_sqi_busy), 0);
                chk("idle_oe", 32'(bus.o_sqi_oe), 0);
            end else if (!rd_win) begin
                chk("oe_window", 32'(bus.o_sqi_oe), 0);
            end
        end
    end

    initial begin
        logic [7:0] q [$];
        logic [3:0] d;
        logic oe;
        logic [23:0] ra;
        int n;

        bus.i_sqi_cs = 1'b1;
        bus.i_sqi_sck = 1'b0;
        bus.i_sqi_data = 4'h0;
        for (int i = 0; i < 256; i++) vld[i] = 1'b0;
        repeat (3) @(negedge gck);
        chk("rst_oe", 32'(bus.o_sqi_oe), 0);
        chk("rst_data", 32'(bus.o_sqi_data), 0);
        chk("rst_busy", 32'(bus.o_sqi_busy), 0);
        rst = 1'b0;
        repeat (2) @(negedge gck);

        // Write then read back.
        q = '{8'hA5, 8'h3C};
        write_tx(24'h000010, q);
        read_tx(24'h000010, 2);
        chk("wr_rd_n0", 32'(rx[0]), 32'hA);
        chk("wr_rd_n1", 32'(rx[1]), 32'h5);
        chk("wr_rd_n2", 32'(rx[2]), 32'h3);
        chk("wr_rd_n3", 32'(rx[3]), 32'hC);

        // Upper address bits ignored, address wraps.
        q = '{8'h11, 8'h22};
        write_tx(24'h1234FF, q);
        read_tx(24'h0000FF, 2);
        chk("wrap_n0", 32'(rx[0]), 32'h1);
        chk("wrap_n1", 32'(rx[1]), 32'h1);
        chk("wrap_n2", 32'(rx[2]), 32'h2);
        chk("wrap_n3", 32'(rx[3]), 32'h2);

        // Unknown command is ignored until deselect.
        @(negedge gck);
        bus.i_sqi_cs = 1'b0;
        send(4'h0);
        send(4'h5);
        for (int i = 0; i < 16; i++) begin
            send(4'($urandom_range(0, 15)));
            chk("ign_busy", 32'(bus.o_sqi_busy), 1);
            chk("ign_oe", 32'(bus.o_sqi_oe), 0);
        end
        end_tx();
        read_tx(24'h000010, 2);
        read_tx(24'h0000FF, 2);

        // Abort mid-byte keeps completed bytes only.
        q = '{8'h00, 8'h5A};
        write_tx(24'h000020, q);
        begin_tx(8'h02, 24'h000020);
        send(4'h7);
        send(4'h7);
        mdl[8'h20] = 8'h77;
        send(4'h9);
        @(negedge gck);
        bus.i_sqi_cs = 1'b1;
        @(posedge gck);
        #1;
        chk("abort_idle", 32'(bus.o_sqi_busy), 0);
        @(negedge gck);
        bus.i_sqi_sck = 1'b0;
        repeat (2) @(negedge gck);
        read_tx(24'h000020, 2);
        chk("abort_n0", 32'(rx[0]), 32'h7);
        chk("abort_n1", 32'(rx[1]), 32'h7);
        chk("abort_n2", 32'(rx[2]), 32'h5);
        chk("abort_n3", 32'(rx[3]), 32'hA);

        // Asynchronous reset in the middle of a read.
        begin_tx(8'h03, 24'h000010);
        send(4'h0);
        send(4'h0);
        rd_win = 1'b1;
        half(1'b0, d, oe);
        half(1'b1, d, oe);
        chk("pre_rst_nib", 32'(d), 32'hA);
        #2;
        rst = 1'b1;
        rd_win = 1'b0;
        #1;
        chk("mid_rst_oe", 32'(bus.o_sqi_oe), 0);
        chk("mid_rst_data", 32'(bus.o_sqi_data), 0);
        chk("mid_rst_busy", 32'(bus.o_sqi_busy), 0);
        @(negedge gck);
        bus.i_sqi_cs = 1'b1;
        bus.i_sqi_sck = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge gck);
        read_tx(24'h000010, 2);
        chk("post_rst_n0", 32'(rx[0]), 32'hA);

        // SCK toggling every gck through a 4-byte read.
        ph = 1;
        q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        write_tx(24'h000040, q);
        read_tx(24'h000040, 4);
        chk("fast_len", rx.size(), 8);
        chk("fast_n7", 32'(rx[7]), 32'hF);

        // Randomized write/read-back traffic at varied SCK rates.
        for (int t = 0; t < 8; t++) begin
            ph = $urandom_range(1, 3);
            ra = 24'($urandom);
            n = $urandom_range(1, 4);
            q.delete();
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            write_tx(ra, q);
            ph = $urandom_range(1, 3);
            read_tx(ra, n);
        end
        for (int t = 0; t < 4; t++) begin
            ph = $urandom_range(1, 3);
            read_tx(24'($urandom), 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
